// File: rtl/count_sequence_checker_pkg.sv
// Shared definitions for the count sequence checker.
//   - DEFAULT_WIDTH  : default width of the monitored down-counter value
//   - DEFAULT_WRAP_W : default width of the saturating wrap counter
//   - state_e        : checker FSM state encoding (2-bit)
package count_sequence_checker_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 3;
  localparam int unsigned DEFAULT_WRAP_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_e;

endpackage

// File: rtl/count_sequence_checker_wrap_counter_sat.sv
// Saturating up-counter used to count detected wrap-arounds.
//   clk   : clock, all state changes on posedge
//   rst   : asynchronous active-high reset, clears the count
//   clr   : synchronous clear, takes priority over inc
//   inc   : increment request; ignored once the count is all-ones
//   count : current count value
module count_sequence_checker_wrap_counter_sat
  import count_sequence_checker_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WRAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != MAX)) begin
      count_q <= count_q + ONE;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Monitor for a WIDTH-bit down-counter. Locks on the first all-ones value,
// then checks every sample follows ONES, ONES-1, ..., 0, ONES. Holds and
// reloads to ONES are legal; anything else latches a sticky error.
//   clk        : clock
//   rst        : asynchronous active-high reset
//   clr        : synchronous clear back to IDLE, zeroes wrap_count/seq_err
//   count_in   : monitored counter value
//   locked     : high while tracking the sequence
//   wrap_pulse : one-cycle pulse per 0 -> all-ones wrap
//   wrap_count : saturating number of wraps since reset/clr
//   seq_err    : sticky sequence error flag
module count_sequence_checker
  import count_sequence_checker_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned WRAP_W = DEFAULT_WRAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              seq_err
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] expected;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic             err_q, err_d;
  logic             wrap_inc;

  assign expected = prev_q - ONE;

  // Any compare against an X/Z sample is not true, so an unknown value in
  // TRACK falls through to the error branch and is ignored in IDLE.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    err_d    = err_q;
    pulse_d  = 1'b0;
    wrap_inc = 1'b0;
    if (clr) begin
      state_d = IDLE;
      prev_d  = ZERO;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_in == ONES) begin
            state_d = TRACK;
            prev_d  = ONES;
          end
        end
        TRACK: begin
          if (count_in == prev_q) begin
            // counter held in its own reset
          end else if ((prev_q != ZERO) && (count_in == expected)) begin
            prev_d = count_in;
          end else if ((prev_q == ZERO) && (count_in == ONES)) begin
            pulse_d  = 1'b1;
            wrap_inc = 1'b1;
            prev_d   = ONES;
          end else if (count_in == ONES) begin
            // reload mid-sequence; prev is neither 0 nor ONES here
            prev_d = ONES;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        ERR: begin
          // sticky until clr or rst
        end
        default: begin
          state_d = IDLE;
          prev_d  = ZERO;
        end
      endcase
    end
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= ZERO;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  count_sequence_checker_wrap_counter_sat #(
    .WIDTH(WRAP_W)
  ) u_wrap_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (wrap_inc),
    .count(wrap_count)
  );

  assign locked     = locked_q;
  assign wrap_pulse = pulse_q;
  assign seq_err    = err_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: one default instance (WRAP_W=8) and one
// narrow instance (WRAP_W=2) share all stimulus; a rule-level model predicts
// both.
module tb_count_sequence_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [2:0] count_in;

  logic       locked_a, pulse_a, err_a;
  logic [7:0] wc_a;
  logic       locked_b, pulse_b, err_b;
  logic [1:0] wc_b;

  always #5 clk = ~clk;

  count_sequence_checker #(
    .WIDTH (3),
    .WRAP_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .count_in  (count_in),
    .locked    (locked_a),
    .wrap_pulse(pulse_a),
    .wrap_count(wc_a),
    .seq_err   (err_a)
  );

  count_sequence_checker #(
    .WIDTH (3),
    .WRAP_W(2)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .count_in  (count_in),
    .locked    (locked_b),
    .wrap_pulse(pulse_b),
    .wrap_count(wc_b),
    .seq_err   (err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lock flag, error flag, last value, unbounded wrap count.
  bit m_locked, m_err, m_pulse;
  int m_prev, m_wraps;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_pulse = 0; m_prev = 0; m_wraps = 0;
  endtask

  task automatic model_step(input int v, input bit isx, input bit c);
    m_pulse = 0;
    if (c) begin
      m_locked = 0; m_err = 0; m_prev = 0; m_wraps = 0;
    end else if (m_err) begin
      // stays in error
    end else if (!m_locked) begin
      if (!isx && v == 7) begin m_locked = 1; m_prev = 7; end
    end else if (isx) begin
      m_err = 1; m_locked = 0;
    end else if (v == m_prev) begin
      // hold
    end else if (m_prev != 0 && v == (m_prev + 7) % 8) begin
      m_prev = v;
    end else if (m_prev == 0 && v == 7) begin
      m_pulse = 1; m_wraps++; m_prev = 7;
    end else if (v == 7) begin
      m_prev = 7;
    end else begin
      m_err = 1; m_locked = 0;
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".locked"}, {31'b0, locked_a}, {31'b0, m_locked});
    chk({where, ".pulse"},  {31'b0, pulse_a},  {31'b0, m_pulse});
    chk({where, ".err"},    {31'b0, err_a},    {31'b0, m_err});
    chk({where, ".wc"},     {24'b0, wc_a},     32'(sat(m_wraps, 255)));
    chk({where, ".locked2"}, {31'b0, locked_b}, {31'b0, m_locked});
    chk({where, ".pulse2"},  {31'b0, pulse_b},  {31'b0, m_pulse});
    chk({where, ".err2"},    {31'b0, err_b},    {31'b0, m_err});
    chk({where, ".wc2"},     {30'b0, wc_b},     32'(sat(m_wraps, 3)));
  endtask

  // Drive one sample, let the edge take it, compare 1 ns later.
  task automatic cyc(input int v, input bit c, input string tag);
    count_in = 3'(v);
    clr      = c;
    @(posedge clk);
    model_step(v, 1'b0, c);
    #1;
    check_all(tag);
  endtask

  task automatic cyc_x(input string tag);
    count_in = 'x;
    clr      = 1'b0;
    @(posedge clk);
    model_step(0, 1'b1, 1'b0);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ".zero_wc"}, {24'b0, wc_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    int v;
    bit c;

    rst = 1'b1; clr = 1'b0; count_in = 3'd7;
    model_reset();
    #50;
    check_all("reset");
    #50;
    rst = 1'b0;

    // Free-running counter for 200 ns: two wraps.
    for (int i = 0; i < 20; i++) cyc(7 - (i % 8), 1'b0, "run");
    chk("run.wc_end", {24'b0, wc_a}, 32'd2);
    chk("run.err_end", {31'b0, err_a}, 32'd0);

    // Skipped step 5 -> 3.
    cyc(7, 1'b0, "skip"); cyc(6, 1'b0, "skip"); cyc(5, 1'b0, "skip"); cyc(3, 1'b0, "skip");
    chk("skip.err", {31'b0, err_a}, 32'd1);
    chk("skip.locked", {31'b0, locked_a}, 32'd0);
    chk("skip.wc", {24'b0, wc_a}, 32'd2);
    cyc(3, 1'b1, "clr");
    chk("clr.err", {31'b0, err_a}, 32'd0);

    // Unknown input in IDLE is ignored.
    for (int i = 0; i < 3; i++) cyc_x("xidle");
    cyc(7, 1'b0, "lock"); cyc(6, 1'b0, "lock");
    chk("lock.locked", {31'b0, locked_a}, 32'd1);

    // Holds and reloads are legal.
    cyc(7, 1'b0, "hold"); cyc(7, 1'b0, "hold"); cyc(7, 1'b0, "hold");
    cyc(6, 1'b0, "hold"); cyc(6, 1'b0, "hold"); cyc(5, 1'b0, "hold");
    cyc(4, 1'b0, "reload"); cyc(7, 1'b0, "reload");
    chk("reload.err", {31'b0, err_a}, 32'd0);
    chk("reload.wc", {24'b0, wc_a}, 32'd0);

    // Four full cycles: narrow instance saturates at 3.
    for (int k = 0; k < 4; k++) begin
      for (int j = 6; j >= 0; j--) cyc(j, 1'b0, "satrun");
      cyc(7, 1'b0, "satwrap");
      chk("sat.pulse", {31'b0, pulse_b}, 32'd1);
      chk("sat.wc", {30'b0, wc_b}, 32'(sat(k + 1, 3)));
    end

    // Asynchronous reset while tracking with two wraps counted.
    cyc(7, 1'b1, "preclr");
    for (int i = 0; i < 17; i++) cyc(7 - (i % 8), 1'b0, "prerst");
    chk("prerst.wc", {24'b0, wc_a}, 32'd2);
    async_reset("arst");

    // Randomized traffic, mostly legal with occasional faults and clears.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      c = 1'b0;
      if (m_err) begin
        c = (r < 30);
        v = int'($urandom_range(0, 7));
      end else if (!m_locked) begin
        v = (r < 50) ? 7 : int'($urandom_range(0, 7));
      end else if (r < 75) begin
        v = (m_prev + 7) % 8;
      end else if (r < 85) begin
        v = m_prev;
      end else if (r < 90) begin
        v = 7;
      end else if (r < 97) begin
        v = int'($urandom_range(0, 7));
      end else begin
        c = 1'b1;
        v = int'($urandom_range(0, 7));
      end
      cyc(v, c, "rand");
      if (i == 200) async_reset("rand_arst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
